// File: rtl/clock_mode_ctrl_pkg.sv
// rtl/clock_mode_ctrl_pkg.sv - shared state encoding and snooze constants
//
// Purpose: state encoding for the clock mode FSM (also driven out on the
// mode port), snooze timing constants and the field-step helpers used by
// the adjust-mode navigation buttons.
// Ports: none (package).
// Configuration: ALARM_SNOOZE_EN selects the snooze feature in alarm_ctrl;
// the constants here exist in both builds.

package clock_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLOCK    = 3'd0,
        ST_ADJ_THR  = 3'd1,
        ST_ADJ_TMIN = 3'd2,
        ST_ADJ_AHR  = 3'd3,
        ST_ADJ_AMIN = 3'd4
    } state_e;

    localparam int SNOOZE_TICKS = 300;
    localparam int SNOOZE_CNT_W = 9;

    // btnr order: THR -> TMIN -> AHR -> AMIN -> THR.
    // Undefined encodings recover to the first adjust field.
    function automatic state_e adj_next(input state_e s);
        case (s)
            ST_ADJ_THR:  adj_next = ST_ADJ_TMIN;
            ST_ADJ_TMIN: adj_next = ST_ADJ_AHR;
            ST_ADJ_AHR:  adj_next = ST_ADJ_AMIN;
            ST_ADJ_AMIN: adj_next = ST_ADJ_THR;
            default:     adj_next = ST_ADJ_THR;
        endcase
    endfunction

    // btnl order is the reverse of adj_next.
    function automatic state_e adj_prev(input state_e s);
        case (s)
            ST_ADJ_THR:  adj_prev = ST_ADJ_AMIN;
            ST_ADJ_TMIN: adj_prev = ST_ADJ_THR;
            ST_ADJ_AHR:  adj_prev = ST_ADJ_TMIN;
            ST_ADJ_AMIN: adj_prev = ST_ADJ_AHR;
            default:     adj_prev = ST_ADJ_THR;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_alarm_ctrl.sv
// rtl/clock_mode_ctrl_alarm_ctrl.sv - alarm edge detect, alarm_on register and snooze
//
// Purpose: detects a rising edge of the external alarm compare while the
// FSM is in CLOCK, holds alarm_on until any button clears it, and (with
// ALARM_SNOOZE_EN defined) re-asserts the alarm SNOOZE_TICKS seconds after
// a lone btnu snooze press.
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   time_match     alarm hh:mm equals time hh:mm
//   in_clock       FSM currently in CLOCK (registered state)
//   any_btn        any button pulse this cycle
//   btnu_only      btnu pulsed with no other button
//   enter_adj      FSM leaves CLOCK at this edge
//   tick_1hz       1 Hz timebase pulse
//   alarm_on       registered alarm drive
// Configuration: ALARM_SNOOZE_EN enables the snooze counter; undefined,
// btnu clears the alarm like any other button and no counter exists.

module alarm_ctrl
    import clock_mode_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic time_match,
    input  logic in_clock,
    input  logic any_btn,
    input  logic btnu_only,
    input  logic enter_adj,
    input  logic tick_1hz,
    output logic alarm_on
);

    logic time_match_q;
    logic alarm_on_q;
    logic alarm_on_d;
    logic match_rise;
    logic alarm_clear;
    logic snooze_fire;

    // time_match_q resets high so a match already present out of reset
    // does not look like a fresh edge. It tracks in every state, so a match
    // that rose during adjust is not seen as an edge on return to CLOCK.
    assign match_rise  = time_match & ~time_match_q;
    assign alarm_clear = alarm_on_q & any_btn;

`ifdef ALARM_SNOOZE_EN
    localparam logic [SNOOZE_CNT_W-1:0] SNOOZE_LAST = SNOOZE_CNT_W'(SNOOZE_TICKS - 1);

    logic                    snooze_act_q;
    logic                    snooze_act_d;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt_q;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt_d;

    always_comb begin
        snooze_act_d = snooze_act_q;
        snooze_cnt_d = snooze_cnt_q;
        snooze_fire  = 1'b0;
        if (alarm_clear && btnu_only) begin
            snooze_act_d = 1'b1;
            snooze_cnt_d = '0;
        end else if (alarm_clear || enter_adj) begin
            snooze_act_d = 1'b0;
            snooze_cnt_d = '0;
        end else if (snooze_act_q && tick_1hz) begin
            if (snooze_cnt_q == SNOOZE_LAST) begin
                snooze_fire  = 1'b1;
                snooze_act_d = 1'b0;
                snooze_cnt_d = '0;
            end else begin
                snooze_cnt_d = snooze_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            snooze_act_q <= 1'b0;
            snooze_cnt_q <= '0;
        end else begin
            snooze_act_q <= snooze_act_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end
`else
    logic unused_snooze_inputs;
    assign unused_snooze_inputs = btnu_only ^ enter_adj ^ tick_1hz;
    assign snooze_fire          = 1'b0;
`endif

    always_comb begin
        alarm_on_d = alarm_on_q;
        if (alarm_clear) begin
            alarm_on_d = 1'b0;
        end else if (in_clock && match_rise) begin
            alarm_on_d = 1'b1;
        end else if (snooze_fire) begin
            alarm_on_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            time_match_q <= 1'b1;
            alarm_on_q   <= 1'b0;
        end else begin
            time_match_q <= time_match;
            alarm_on_q   <= alarm_on_d;
        end
    end

    assign alarm_on = alarm_on_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - clock / time-adjust / alarm-adjust mode controller
//
// Purpose: five-state FSM (CLOCK plus four adjust fields) driven by button
// pulses, with a zero-latency decode of the counter enables and count
// direction. Alarm handling lives in alarm_ctrl.
// Ports:
//   clk                      system clock, rising edge
//   reset                    synchronous active-low reset
//   tick_1hz                 1 Hz timebase pulse
//   btnc/btnu/btnd/btnl/btnr debounced single-cycle button pulses
//   sec_max/min_max/hr_max   time counters at terminal count
//   time_match               alarm hh:mm equals time hh:mm
//   sec_en/min_en/hr_en      time counter enables
//   amin_en/ahr_en           alarm counter enables
//   up_down                  shared count direction, 1 = up
//   mode                     registered FSM state encoding
//   adjust                   registered, high in any adjust state
//   alarm_on                 registered alarm drive
// Configuration: ALARM_SNOOZE_EN (see alarm_ctrl).

module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btnc,
    input  logic       btnu,
    input  logic       btnd,
    input  logic       btnl,
    input  logic       btnr,
    input  logic       sec_max,
    input  logic       min_max,
    input  logic       hr_max,
    input  logic       time_match,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       amin_en,
    output logic       ahr_en,
    output logic       up_down,
    output logic [2:0] mode,
    output logic       adjust,
    output logic       alarm_on
);

    logic   resetn;
    state_e state_q;
    state_e state_d;
    logic   adjust_q;
    logic   adjust_d;
    logic   alarm_on_w;
    logic   any_btn;
    logic   btn_consume;
    logic   btnu_only;
    logic   in_clock;
    logic   enter_adj;
    logic   field_step;

    // Hour rollover is handled by the hour counter itself.
    logic unused_hr_max;
    assign unused_hr_max = hr_max;

    assign resetn      = reset;
    assign any_btn     = btnc | btnu | btnd | btnl | btnr;
    assign btnu_only   = btnu & ~(btnc | btnd | btnl | btnr);
    assign in_clock    = (state_q == ST_CLOCK);
    // While the alarm sounds, a button only silences it.
    assign btn_consume = alarm_on_w & any_btn;

    always_comb begin
        state_d = state_q;
        if (!btn_consume) begin
            case (state_q)
                ST_CLOCK: begin
                    if (btnc) state_d = ST_ADJ_THR;
                end
                default: begin
                    if (btnc)      state_d = ST_CLOCK;
                    else if (btnr) state_d = adj_next(state_q);
                    else if (btnl) state_d = adj_prev(state_q);
                end
            endcase
        end
    end

    assign enter_adj = in_clock & (state_d != ST_CLOCK);
    assign adjust_d  = (state_d != ST_CLOCK);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_CLOCK;
            adjust_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adjust_q <= adjust_d;
        end
    end

    // Up/down steps only when neither a higher-priority navigation button
    // nor the opposite direction is pressed in the same cycle.
    assign field_step = ~btn_consume & ~btnc & ~btnr & ~btnl & (btnu ^ btnd);

    always_comb begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hr_en   = 1'b0;
        amin_en = 1'b0;
        ahr_en  = 1'b0;
        up_down = 1'b1;
        if (resetn) begin
            if (in_clock) begin
                sec_en = tick_1hz;
                min_en = tick_1hz & sec_max;
                hr_en  = tick_1hz & sec_max & min_max;
            end else if (field_step) begin
                up_down = btnu;
                case (state_q)
                    ST_ADJ_THR:  hr_en   = 1'b1;
                    ST_ADJ_TMIN: min_en  = 1'b1;
                    ST_ADJ_AHR:  ahr_en  = 1'b1;
                    ST_ADJ_AMIN: amin_en = 1'b1;
                    default:     ;
                endcase
            end
        end
    end

    alarm_ctrl u_alarm_ctrl (
        .clk        (clk),
        .resetn     (resetn),
        .time_match (time_match),
        .in_clock   (in_clock),
        .any_btn    (any_btn),
        .btnu_only  (btnu_only),
        .enter_adj  (enter_adj),
        .tick_1hz   (tick_1hz),
        .alarm_on   (alarm_on_w)
    );

    assign mode     = state_q;
    assign adjust   = adjust_q;
    assign alarm_on = alarm_on_w;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - self-checking bench for clock_mode_ctrl

module tb_clock_mode_ctrl;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       bc, bu, bd, bl, br;
    logic       smax, mmax, hmax;
    logic       tm;
    logic       sec_en, min_en, hr_en, amin_en, ahr_en, up_down;
    logic [2:0] mode;
    logic       adjust, alarm_on;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    clock_mode_ctrl dut (
        .clk        (clk),
        .reset      (rst_n),
        .tick_1hz   (tick),
        .btnc       (bc),
        .btnu       (bu),
        .btnd       (bd),
        .btnl       (bl),
        .btnr       (br),
        .sec_max    (smax),
        .min_max    (mmax),
        .hr_max     (hmax),
        .time_match (tm),
        .sec_en     (sec_en),
        .min_en     (min_en),
        .hr_en      (hr_en),
        .amin_en    (amin_en),
        .ahr_en     (ahr_en),
        .up_down    (up_down),
        .mode       (mode),
        .adjust     (adjust),
        .alarm_on   (alarm_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m = 0 for CLOCK, 1..4 for the adjust fields in btnr order.
    int       m = 0;
    int       nm;
    bit       alm = 1'b0;
    bit       tmq = 1'b1;
    bit       snz_act = 1'b0;
    int       snz_left = 0;
    bit       fire;
    bit       any_b, cons;
    bit [4:0] exp_en;
    bit       exp_ud;

    always @(negedge clk) begin
        any_b  = bc | bu | bd | bl | br;
        cons   = alm && any_b;
        exp_en = 5'b0;
        exp_ud = 1'b1;
        if (rst_n) begin
            if (m == 0) begin
                exp_en = {tick, tick & smax, tick & smax & mmax, 2'b00};
            end else if (!cons && !bc && !br && !bl && (bu != bd)) begin
                exp_ud = bu;
                case (m)
                    1: exp_en = 5'b00100;
                    2: exp_en = 5'b01000;
                    3: exp_en = 5'b00001;
                    4: exp_en = 5'b00010;
                    default: exp_en = 5'b0;
                endcase
            end
        end
        if (chk_en) begin
            tests++;
            if ({sec_en, min_en, hr_en, amin_en, ahr_en, up_down, mode, adjust, alarm_on} !==
                {exp_en, exp_ud, 3'(m), (m != 0), alm}) begin
                fails++;
                $display("FAIL model t=%0t got en=%b ud=%b mode=%0d adj=%b alarm=%b expected en=%b ud=%b mode=%0d adj=%b alarm=%b",
                         $time, {sec_en, min_en, hr_en, amin_en, ahr_en}, up_down, mode, adjust, alarm_on,
                         exp_en, exp_ud, m, (m != 0), alm);
            end
        end
        if (!rst_n) begin
            m = 0; alm = 1'b0; tmq = 1'b1; snz_act = 1'b0; snz_left = 0;
        end else begin
            nm = m;
            if (!cons) begin
                if (m == 0) begin
                    if (bc) nm = 1;
                end else if (bc) nm = 0;
                else if (br) nm = m % 4 + 1;
                else if (bl) nm = (m + 2) % 4 + 1;
            end
            fire = 1'b0;
            if (cons) begin
                if (SNZ && bu && !(bc | bd | bl | br)) begin
                    snz_act = 1'b1; snz_left = 300;
                end else snz_act = 1'b0;
            end else if (m == 0 && nm != 0) begin
                snz_act = 1'b0;
            end else if (snz_act && tick) begin
                snz_left--;
                if (snz_left == 0) begin fire = 1'b1; snz_act = 1'b0; end
            end
            if (cons) alm = 1'b0;
            else if (m == 0 && tm && !tmq) alm = 1'b1;
            else if (fire) alm = 1'b1;
            tmq = tm;
            m   = nm;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        tick = 0; bc = 0; bu = 0; bd = 0; bl = 0; br = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 0; tick = 0; bc = 0; bu = 0; bd = 0; bl = 0; br = 0;
        smax = 0; mmax = 0; hmax = 0; tm = 0;
        cyc(); cyc();
        rst_n = 1; chk_en = 1'b1;
        chk("reset_mode", mode, 0);
        chk("reset_adjust", adjust, 0);
        chk("reset_alarm", alarm_on, 0);

        // Full rollover tick in CLOCK.
        smax = 1; mmax = 1; hmax = 0; tick = 1; #1;
        chk("roll_en", {sec_en, min_en, hr_en}, 3'b111);
        chk("roll_ud", up_down, 1);
        cyc(); #1;
        chk("roll_one_cycle", {sec_en, min_en, hr_en}, 3'b000);
        smax = 0; mmax = 0;

        // Navigate to ADJ_AHR and step down.
        bc = 1; cyc();
        chk("adj_enter_mode", mode, 1);
        chk("adj_enter_adjust", adjust, 1);
        br = 1; cyc(); br = 1; cyc();
        chk("adj_ahr_mode", mode, 3);
        bd = 1; #1;
        chk("ahr_down_en", {hr_en, min_en, ahr_en, amin_en}, 4'b0010);
        chk("ahr_down_ud", up_down, 0);
        cyc(); #1;
        chk("ahr_en_one_cycle", ahr_en, 0);
        tick = 1; #1;
        chk("adj_sec_frozen", sec_en, 0);
        cyc();
        bc = 1; cyc();
        chk("adj_exit_mode", mode, 0);

        // Alarm rise then any button clears it without side effects.
        tm = 1; cyc();
        chk("alarm_set", alarm_on, 1);
        bl = 1; #1;
        chk("alarm_clear_no_en", {sec_en, min_en, hr_en, amin_en, ahr_en}, 5'b0);
        cyc();
        chk("alarm_cleared", alarm_on, 0);
        chk("alarm_clear_mode", mode, 0);

        // btnc beats btnr.
        bc = 1; br = 1; cyc();
        chk("prio_c_over_r", mode, 1);
        bc = 1; cyc();

        // Match rising while adjusting must not fire on return.
        bc = 1; cyc();
        tm = 0; cyc(); tm = 1; cyc(); cyc();
        bc = 1; cyc(); cyc();
        chk("no_stale_match", alarm_on, 0);
        tm = 0; cyc(); tm = 1; cyc();
        chk("fresh_match", alarm_on, 1);

        // Snooze.
        bu = 1; cyc();
        chk("snooze_clear", alarm_on, 0);
        repeat (299) begin tick = 1; cyc(); end
        chk("snooze_early", alarm_on, 0);
        tick = 1; cyc();
        chk("snooze_fire", alarm_on, SNZ);
        bl = 1; cyc();
        chk("snooze_off", alarm_on, 0);

        // Reset mid-adjust.
        bc = 1; cyc(); br = 1; cyc();
        chk("tmin_mode", mode, 2);
        rst_n = 0; bu = 1; br = 1; tick = 1; #1;
        chk("reset_no_en", {sec_en, min_en, hr_en, amin_en, ahr_en}, 5'b0);
        cyc();
        chk("rst_adj_mode", mode, 0);
        chk("rst_adj_adjust", adjust, 0);
        rst_n = 1;

        // Alarm and adjust entered on the same edge, then reset.
        tm = 0; cyc();
        tm = 1; bc = 1; cyc();
        chk("alarm_and_adj_alarm", alarm_on, 1);
        chk("alarm_and_adj_mode", mode, 1);
        rst_n = 0; bl = 1; cyc();
        chk("rst_alarm_alarm", alarm_on, 0);
        chk("rst_alarm_mode", mode, 0);
        rst_n = 1; cyc();

        // Randomized phase checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            tick  = ($urandom_range(0, 3) == 0);
            bc    = ($urandom_range(0, 9) == 0);
            bu    = ($urandom_range(0, 7) == 0);
            bd    = ($urandom_range(0, 7) == 0);
            bl    = ($urandom_range(0, 9) == 0);
            br    = ($urandom_range(0, 9) == 0);
            smax  = 1'($urandom_range(0, 1));
            mmax  = 1'($urandom_range(0, 1));
            hmax  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) tm = ~tm;
            @(posedge clk);
            #1;
        end
        rst_n = 1;
        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
